// File: rtl/sb_packet_deframing_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the sideband receive-path deframer:
//   - phase and header widths
//   - opcode field position and the data-bearing opcode list (sb_has_data)
//   - timeout-class field position and the "stop timeout counter" value
//   - deframer FSM state encoding
//   - even-parity helper used by the optional parity checker
// -----------------------------------------------------------------------------
package sb_pkg;

    localparam int HDR_W   = 62;
    localparam int PHASE_W = 64;

    // Header phase bit positions for the control and data parity bits
    localparam int CP_BIT = 62;
    localparam int DP_BIT = 63;

    // Opcode field
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 4;

    localparam logic [4:0] OPC_DATA_0 = 5'b00001;
    localparam logic [4:0] OPC_DATA_1 = 5'b00101;
    localparam logic [4:0] OPC_DATA_2 = 5'b01001;
    localparam logic [4:0] OPC_DATA_3 = 5'b11001;
    localparam logic [4:0] OPC_DATA_4 = 5'b11011;

    // Timeout-class field
    localparam int         TMO_LSB      = 14;
    localparam int         TMO_MSB      = 17;
    localparam logic [3:0] TMO_STOP_VAL = 4'd5;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } sb_deframe_state_e;

    // True when the opcode is followed by a data phase
    function automatic logic sb_has_data(input logic [4:0] opcode);
        logic result;
        case (opcode)
            OPC_DATA_0,
            OPC_DATA_1,
            OPC_DATA_2,
            OPC_DATA_3,
            OPC_DATA_4: result = 1'b1;
            default:    result = 1'b0;
        endcase
        return result;
    endfunction

    // Even parity (XOR reduction) of a full phase-width vector
    function automatic logic sb_parity(input logic [PHASE_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/sb_packet_deframing_hold_reg.sv
// -----------------------------------------------------------------------------
// sb_deframe_hold_reg
// Single-entry valid/ready holding register between the deframer and the
// sideband message decoder. A new packet loads when the register is empty or
// is being consumed in the same cycle; otherwise it is dropped and an overflow
// pulse is raised. Held contents never change while pkt_valid is high except
// through a simultaneous consume+load.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pkt_in_valid      a good, complete packet is offered this cycle
//   pkt_in_header     offered header
//   pkt_in_data       offered data phase (0 for header-only)
//   pkt_in_has_data   offered packet carried a data phase
//   pkt_ready         downstream consumes the held packet
//   accept            combinational: the offered packet loads this cycle
//   pkt_valid         register full
//   header/data/has_data  held packet
//   overflow          one-cycle pulse: offered packet was dropped
// -----------------------------------------------------------------------------
module sb_deframe_hold_reg
    import sb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_in_valid,
    input  logic [HDR_W-1:0]   pkt_in_header,
    input  logic [PHASE_W-1:0] pkt_in_data,
    input  logic               pkt_in_has_data,
    input  logic               pkt_ready,
    output logic               accept,
    output logic               pkt_valid,
    output logic [HDR_W-1:0]   header,
    output logic [PHASE_W-1:0] data,
    output logic               has_data,
    output logic               overflow
);

    logic               valid_r;
    logic [HDR_W-1:0]   header_r;
    logic [PHASE_W-1:0] data_r;
    logic               has_data_r;
    logic               overflow_r;

    logic               consume_s;
    logic               accept_s;
    logic               drop_s;

    // Load / consume / drop decisions for the current cycle
    always_comb begin
        consume_s = valid_r & pkt_ready;
        accept_s  = pkt_in_valid & (~valid_r | pkt_ready);
        drop_s    = pkt_in_valid & valid_r & ~pkt_ready;
    end

    // Holding register state and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            header_r   <= '0;
            data_r     <= '0;
            has_data_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                valid_r    <= 1'b1;
                header_r   <= pkt_in_header;
                data_r     <= pkt_in_data;
                has_data_r <= pkt_in_has_data;
            end else if (consume_s) begin
                valid_r    <= 1'b0;
            end else begin
                valid_r    <= valid_r;
            end
            overflow_r <= drop_s;
        end
    end

    assign accept    = accept_s;
    assign pkt_valid = valid_r;
    assign header    = header_r;
    assign data      = data_r;
    assign has_data  = has_data_r;
    assign overflow  = overflow_r;

endmodule

// File: rtl/sb_packet_deframing.sv
// -----------------------------------------------------------------------------
// sb_packet_deframing
// Sideband receive-path deframer. Reassembles header-only and header+data
// packets from 64-bit deserialized phases, optionally checks control/data
// parity, and hands complete packets to the message decoder through a
// single-entry valid/ready holding register.
//
// Header phase: [61:0] header, [62] CP = ^header, [63] DP = ^data (0 when no
// data phase follows). The opcode in header[4:0] decides whether a data phase
// follows.
//
// Build option:
//   SB_DEFRAME_PARITY_CHK_EN  defined: drop packets with a CP/DP mismatch and
//                             pulse o_parity_err. Undefined: CP/DP ignored,
//                             o_parity_err tied low, no parity logic built.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_deser_data/valid    one phase per valid pulse from the deserializer
//   i_pkt_ready           downstream consumes the held packet
//   o_pkt_valid           holding register full
//   o_header/o_data       held packet (o_data = 0 for header-only packets)
//   o_has_data            held packet carried a data phase
//   o_parity_err          pulse: packet dropped on parity
//   o_overflow            pulse: good packet dropped, holding register full
//   o_timeout_ctr_stop    pulse: accepted packet has timeout class 5
// -----------------------------------------------------------------------------
module sb_packet_deframing
    import sb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PHASE_W-1:0] i_deser_data,
    input  logic               i_deser_valid,
    input  logic               i_pkt_ready,
    output logic               o_pkt_valid,
    output logic [HDR_W-1:0]   o_header,
    output logic [PHASE_W-1:0] o_data,
    output logic               o_has_data,
    output logic               o_parity_err,
    output logic               o_overflow,
    output logic               o_timeout_ctr_stop
);

    sb_deframe_state_e  state_r;
    sb_deframe_state_e  next_state_s;
    logic [HDR_W-1:0]   hdr_r;

    logic               hdr_capture_s;
    logic               complete_s;
    logic [HDR_W-1:0]   cpl_hdr_s;
    logic [PHASE_W-1:0] cpl_data_s;
    logic               cpl_has_data_s;
    logic               good_s;
    logic               accept_s;
    logic               tstop_r;

    // Next-state and completed-packet assembly. A header-only packet completes
    // straight from the incoming phase; a data packet completes from the
    // latched header plus the incoming data phase.
    always_comb begin
        next_state_s   = state_r;
        hdr_capture_s  = 1'b0;
        complete_s     = 1'b0;
        cpl_hdr_s      = hdr_r;
        cpl_data_s     = '0;
        cpl_has_data_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cpl_hdr_s = i_deser_data[HDR_W-1:0];
                if (i_deser_valid) begin
                    hdr_capture_s = 1'b1;
                    if (sb_has_data(i_deser_data[OPC_MSB:OPC_LSB])) begin
                        next_state_s = ST_WAIT_DATA;
                    end else begin
                        complete_s   = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (i_deser_valid) begin
                    complete_s     = 1'b1;
                    cpl_data_s     = i_deser_data;
                    cpl_has_data_s = 1'b1;
                    next_state_s   = ST_IDLE;
                end else begin
                    next_state_s   = ST_WAIT_DATA;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latched header of the packet in progress
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hdr_r <= '0;
        end else if (hdr_capture_s) begin
            hdr_r <= i_deser_data[HDR_W-1:0];
        end else begin
            hdr_r <= hdr_r;
        end
    end

`ifdef SB_DEFRAME_PARITY_CHK_EN
    logic cp_r;
    logic dp_r;
    logic cpl_cp_s;
    logic cpl_dp_s;
    logic perr_r;

    // Latched parity bits of the packet in progress
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cp_r <= 1'b0;
            dp_r <= 1'b0;
        end else if (hdr_capture_s) begin
            cp_r <= i_deser_data[CP_BIT];
            dp_r <= i_deser_data[DP_BIT];
        end else begin
            cp_r <= cp_r;
            dp_r <= dp_r;
        end
    end

    // Parity check of the completing packet; data is 0 for header-only packets
    always_comb begin
        if (state_r == ST_IDLE) begin
            cpl_cp_s = i_deser_data[CP_BIT];
            cpl_dp_s = i_deser_data[DP_BIT];
        end else begin
            cpl_cp_s = cp_r;
            cpl_dp_s = dp_r;
        end
        good_s = (cpl_cp_s == sb_parity({2'b00, cpl_hdr_s})) &
                 (cpl_dp_s == sb_parity(cpl_data_s));
    end

    // Parity error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perr_r <= 1'b0;
        end else begin
            perr_r <= complete_s & ~good_s;
        end
    end

    assign o_parity_err = perr_r;
`else
    assign good_s       = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    sb_deframe_hold_reg u_hold (
        .clk             (i_clk),
        .rst_n           (i_rst_n),
        .pkt_in_valid    (complete_s & good_s),
        .pkt_in_header   (cpl_hdr_s),
        .pkt_in_data     (cpl_data_s),
        .pkt_in_has_data (cpl_has_data_s),
        .pkt_ready       (i_pkt_ready),
        .accept          (accept_s),
        .pkt_valid       (o_pkt_valid),
        .header          (o_header),
        .data            (o_data),
        .has_data        (o_has_data),
        .overflow        (o_overflow)
    );

    // Timeout-counter stop pulse for accepted packets of timeout class 5
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tstop_r <= 1'b0;
        end else begin
            tstop_r <= accept_s & (cpl_hdr_s[TMO_MSB:TMO_LSB] == TMO_STOP_VAL);
        end
    end

    assign o_timeout_ctr_stop = tstop_r;

endmodule

// File: doc/sb_packet_deframing.md
# sb_packet_deframing

Sideband receive-path deframer: the counterpart of the sideband packet framer. It takes 64-bit phases from the sideband deserializer and reassembles header-only or header+data packets. It checks control and data parity, and presents each complete packet through a single-entry holding register with a valid/ready handshake to the sideband message decoder. It sits between the sideband deserializer and the RX message decode logic.

## Interface
- No parameters; widths are fixed by the package.
- `i_clk`  in  1  sideband logic clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_deser_data`  in  64  deserialized phase.
- `i_deser_valid`  in  1  one-cycle pulse per phase, qualifying `i_deser_data`.
- `i_pkt_ready`  in  1  downstream consumes the held packet.
- `o_pkt_valid`  out  1  holding register full.
- `o_header`  out  62  packet header bits [61:0].
- `o_data`  out  64  data phase; 0 for header-only packets.
- `o_has_data`  out  1  packet carried a data phase.
- `o_parity_err`  out  1  one-cycle pulse: a packet was dropped on parity.
- `o_overflow`  out  1  one-cycle pulse: a good packet was dropped because the holding register was full.
- `o_timeout_ctr_stop`  out  1  one-cycle pulse: a good packet with header[17:14] == 4'd5 was accepted into the holding register.

## Operation
- Header phase layout:
  - [61:0] = header.
  - [62] = CP = ^header[61:0].
  - [63] = DP = ^data; DP is 0 for header-only packets.
- Data presence is decided by opcode header[4:0].
  - Data-bearing opcodes: 5'b00001, 5'b00101, 5'b01001, 5'b11001, 5'b11011.
  - All other opcodes are header-only.
- FSM states: ST_IDLE, ST_WAIT_DATA.
  - ST_IDLE + `i_deser_valid`:
    - Latch header, CP, DP.
    - Data-bearing opcode: go to ST_WAIT_DATA.
    - Otherwise: packet complete this cycle, stay in ST_IDLE.
  - ST_WAIT_DATA + `i_deser_valid`:
    - Latch data; packet complete this cycle; go to ST_IDLE.
  - ST_WAIT_DATA with no `i_deser_valid`: hold indefinitely. There is no internal timeout.
- Packet good = (CP == ^header) and (DP == ^data), where data = 0 for header-only packets.
- On completion:
  - Bad packet: drop it, pulse `o_parity_err`. The holding register is untouched.
  - Good packet, and the holding register is empty or being consumed this cycle (`o_pkt_valid & i_pkt_ready`): load the packet and set `o_pkt_valid`. Pulse `o_timeout_ctr_stop` if header[17:14] == 4'd5.
  - Good packet, holding register full and not consumed: drop the new packet and pulse `o_overflow`. Held contents are unchanged.
- Holding register:
  - `o_pkt_valid & i_pkt_ready` with no simultaneous load: clear `o_pkt_valid`.
  - `o_header`, `o_data` and `o_has_data` are stable while `o_pkt_valid` is high.

## Timing
- Reset: every output is 0, the FSM is in ST_IDLE, and latched header/data are 0.
- Reset asserted mid-packet aborts the packet. The first phase after reset is treated as a header.
- Header-only packet:
  - Header phase at posedge N.
  - `o_pkt_valid` is high from cycle N+1.
  - Status pulses are high during N+1 only.
- Data packet:
  - Header at N, data at M > N.
  - Delivery and pulses occur at M+1.
  - Back-to-back phases (M = N+1) are supported.
- A consume and a load in the same cycle: `o_pkt_valid` stays 1 and the new contents appear the next cycle.
- Throughput: one phase per cycle, sustained.

## Configuration
- `SB_DEFRAME_PARITY_CHK_EN` defined:
  - Parity is checked as above.
  - Bad packets are dropped and `o_parity_err` pulses.
- `SB_DEFRAME_PARITY_CHK_EN` undefined:
  - CP/DP are ignored and every packet is treated as good.
  - `o_parity_err` is tied to 0.
  - No parity XOR trees are synthesized.

## Structure
- Shared package `sb_pkg`:
  - Phase-width constants: header 62, phase 64.
  - Opcode field position [4:0] and the data-bearing opcode list.
  - Function `sb_has_data(opcode)`.
  - Timeout-class field [17:14] and value 4'd5.
  - FSM state enum.
- One natural sub-module: `sb_deframe_hold_reg`, the single-entry valid/ready holding register with load/consume/overflow logic.
- Parity checks and the FSM live in the top module.

## Test plan
- Header-only packet:
  - Stimulus: header = 62'h0000_0000_0001_4012 (opcode 5'b10010, [17:14] = 5), CP correct, DP = 0, ready held at 1.
  - Response: `o_pkt_valid` high at N+1; `o_has_data` = 0; `o_data` = 0; `o_timeout_ctr_stop` pulses; `o_parity_err` = 0.
- Data packet with a gap:
  - Stimulus: opcode 5'b11011 header at N; data 64'hDEAD_BEEF_0123_4567 five cycles later with correct DP.
  - Response: delivery at M+1 with `o_data` equal to the data value; `o_has_data` = 1.
- CP error:
  - Stimulus: header with CP flipped (with the macro defined).
  - Response: `o_parity_err` pulses, no `o_pkt_valid`, FSM back in ST_IDLE.
- DP error:
  - Stimulus: data packet with DP flipped.
  - Response: packet dropped and `o_parity_err` pulses.
  - Repeat without the macro: packet delivered, `o_parity_err` = 0.
- Back-pressure:
  - Stimulus: `i_pkt_ready` = 0; two header-only packets.
  - Response: first packet held; `o_overflow` pulses at the second packet's completion; held header unchanged.
  - Then: ready = 1 concurrent with a third packet's completion. Response: `o_pkt_valid` stays 1 and the third header appears.
- Reset mid-packet:
  - Stimulus: reset asserted in ST_WAIT_DATA, then a header-only packet.
  - Response: all outputs 0 during reset; the next phase is decoded as a header and delivered normally.
